// File: rtl/jfif_word_packer.sv
// Frames a JFIF byte stream on SOI/EOI markers, packs frame bytes big-endian into
// 32-bit words and buffers them in a word FIFO feeding a valid/ready stream.
module jfif_word_packer #(
  parameter int DEPTH        = 512,
  parameter int AFULL_MARGIN = 4,
  parameter int LEN_W        = 24
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [7:0]       JFIF_data,
  input  logic             fifo_wr_req,
  output logic             fifo_full,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_len_vld,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 37;

  typedef enum logic {HUNT, FRAME} state_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] keep_mask(input logic [2:0] filled);
    case (filled)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] slot,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (slot)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             prev_ff_q, prev_ff_d;
  logic [31:0]      pack_q, pack_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             push_vld_q, push_vld_d;
  logic [31:0]      push_data_q, push_data_d;
  logic [3:0]       push_keep_q, push_keep_d;
  logic             push_last_q, push_last_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             out_vld_q, out_vld_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             len_vld_q, len_vld_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic [2:0]       filled;
  logic [31:0]      pack_ins;
  logic             is_eoi;
  logic             pop, wr_ok, mem_we;
  logic [CW-1:0]    mem_cnt;
  logic [EW-1:0]    head;

  // Byte stage: marker detection and packing; completed words go to the push register
  always_comb begin
    state_d     = state_q;
    prev_ff_d   = prev_ff_q;
    pack_d      = pack_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    push_vld_d  = 1'b0;
    push_data_d = push_data_q;
    push_keep_d = push_keep_q;
    push_last_d = push_last_q;
    filled      = {1'b0, cnt_q} + 3'd1;
    pack_ins    = insert_byte(pack_q, cnt_q, JFIF_data);
    is_eoi      = prev_ff_q && (JFIF_data == 8'hD9);
    if (fifo_wr_req) begin
      prev_ff_d = (JFIF_data == 8'hFF);
      if (state_q == HUNT) begin
        if (prev_ff_q && (JFIF_data == 8'hD8)) begin
          state_d    = FRAME;
          pack_d     = 32'hFFD8_0000;
          cnt_d      = 2'd2;
          byte_cnt_d = LEN_W'(2);
        end
      end else begin
        byte_cnt_d = sat_inc(byte_cnt_q);
        if (is_eoi || (cnt_q == 2'd3)) begin
          push_vld_d  = 1'b1;
          push_data_d = pack_ins;
          push_keep_d = keep_mask(filled);
          push_last_d = is_eoi;
          pack_d      = '0;
          cnt_d       = 2'd0;
          if (is_eoi) state_d = HUNT;
        end else begin
          pack_d = pack_ins;
          cnt_d  = cnt_q + 2'd1;
        end
      end
    end
  end

  // FIFO stage: occupancy counts the registered head plus the memory behind it
  always_comb begin
    pop        = out_vld_q && m_ready;
    wr_ok      = push_vld_q && (occ_q != CW'(DEPTH));
    mem_cnt    = occ_q - CW'(out_vld_q);
    head       = mem_q[rd_ptr_q];
    mem_we     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    if (!out_vld_q || pop) begin
      if (mem_cnt != '0) begin
        out_vld_d  = 1'b1;
        out_data_d = head[31:0];
        out_keep_d = head[35:32];
        out_last_d = head[36];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        mem_we     = wr_ok;
      end else if (wr_ok) begin
        out_vld_d  = 1'b1;
        out_data_d = push_data_q;
        out_keep_d = push_keep_q;
        out_last_d = push_last_q;
      end else begin
        out_vld_d = 1'b0;
      end
    end else begin
      mem_we = wr_ok;
    end
    wr_ptr_d  = mem_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    occ_d     = occ_q + CW'(wr_ok) - CW'(pop);
    full_d    = (DEPTH - int'(occ_q)) <= AFULL_MARGIN;
    ovf_d     = ovf_q || (push_vld_q && !wr_ok);
    // The length is reported even when the last word itself is dropped
    len_vld_d = push_vld_q && push_last_q;
    len_d     = len_vld_d ? byte_cnt_q : len_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= HUNT;
      prev_ff_q   <= 1'b0;
      pack_q      <= '0;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      push_vld_q  <= 1'b0;
      push_data_q <= '0;
      push_keep_q <= '0;
      push_last_q <= 1'b0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      len_q       <= '0;
      len_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_ff_q   <= prev_ff_d;
      pack_q      <= pack_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      push_vld_q  <= push_vld_d;
      push_data_q <= push_data_d;
      push_keep_q <= push_keep_d;
      push_last_q <= push_last_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      len_q       <= len_d;
      len_vld_q   <= len_vld_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {push_last_q, push_keep_q, push_data_q};
  end

  assign fifo_full     = full_q;
  assign m_data        = out_data_q;
  assign m_keep        = out_keep_q;
  assign m_last        = out_last_q;
  assign m_valid       = out_vld_q;
  assign frame_len     = len_q;
  assign frame_len_vld = len_vld_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_jfif_word_packer.sv
// Bench for jfif_word_packer: scenario tasks checked against a byte-level frame model.
module tb_jfif_word_packer;
  localparam int DEPTH = 8;
  localparam int AFULL = 4;
  localparam int LEN_W = 24;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [7:0]       JFIF_data = 8'h00;
  logic             fifo_wr_req = 1'b0;
  logic             fifo_full;
  logic [31:0]      m_data;
  logic [3:0]       m_keep;
  logic             m_last;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [LEN_W-1:0] frame_len;
  logic             frame_len_vld;
  logic             overflow;

  jfif_word_packer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFULL), .LEN_W(LEN_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .JFIF_data(JFIF_data), .fifo_wr_req(fifo_wr_req),
    .fifo_full(fifo_full), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .frame_len(frame_len),
    .frame_len_vld(frame_len_vld), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [36:0] exp_w[$];
  logic [36:0] got_w[$];
  int exp_len[$];
  int got_len[$];
  int got_cyc[$];
  int len_cyc[$];
  int byte_cyc[$];

  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (m_valid && m_ready) begin
        got_w.push_back({m_last, m_keep, m_data});
        got_cyc.push_back(cyc);
      end
      if (frame_len_vld) begin
        got_len.push_back(int'(frame_len));
        len_cyc.push_back(cyc);
      end
    end
  end

  // Reference: collect each frame's bytes, then cut them into 4-byte words
  task automatic emit_frame(input logic [7:0] fb[$], input bit closed);
    int n, nw, idx, maxlen;
    logic [31:0] d;
    logic [3:0] k;
    n = fb.size();
    nw = closed ? (n + 3) / 4 : n / 4;
    maxlen = (1 << LEN_W) - 1;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * w + j;
        if (idx < n) begin
          d[31-8*j -: 8] = fb[idx];
          k[3-j] = 1'b1;
        end
      end
      exp_w.push_back({closed && (w == nw - 1), k, d});
    end
    if (closed) exp_len.push_back(n > maxlen ? maxlen : n);
  endtask

  task automatic model_run(input logic [8:0] s[$]);
    logic [7:0] fb[$];
    logic [7:0] b;
    bit in_frame, prev_ff;
    in_frame = 0;
    prev_ff = 0;
    exp_w.delete();
    exp_len.delete();
    foreach (s[i]) begin
      if (s[i][8]) begin
        b = s[i][7:0];
        if (!in_frame) begin
          if (prev_ff && b == 8'hD8) begin
            in_frame = 1;
            fb.delete();
            fb.push_back(8'hFF);
            fb.push_back(8'hD8);
          end
        end else begin
          fb.push_back(b);
          if (prev_ff && b == 8'hD9) begin
            emit_frame(fb, 1);
            in_frame = 0;
          end
        end
        prev_ff = (b == 8'hFF);
      end
    end
    if (in_frame) emit_frame(fb, 0);
  endtask

  task automatic clear_obs();
    got_w.delete();
    got_len.delete();
    got_cyc.delete();
    len_cyc.delete();
    byte_cyc.delete();
  endtask

  task automatic do_reset(input logic rdy);
    sys_rst = 1'b1;
    fifo_wr_req = 1'b0;
    m_ready = rdy;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear_obs();
  endtask

  task automatic send_stream(input logic [8:0] s[$], input bit toggle);
    foreach (s[i]) begin
      JFIF_data = s[i][7:0];
      fifo_wr_req = s[i][8];
      byte_cyc.push_back(cyc);
      if (toggle) m_ready = !m_ready;
      @(posedge sys_clk);
      #1;
    end
    fifo_wr_req = 1'b0;
  endtask

  task automatic idle(input int n, input bit toggle);
    repeat (n) begin
      if (toggle) m_ready = !m_ready;
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_valid); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL rst_keep got %h want 0", m_keep); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", m_data); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    checks++; if ({frame_len_vld, m_last, frame_len} !== '0) begin
      errors++; $display("FAIL rst_len got vld=%b last=%b len=%0d want 0", frame_len_vld, m_last, frame_len);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    logic [8:0] s[$];
    logic [36:0] w;
    b = '{8'h00, 8'hFF, 8'hD8, 8'h01, 8'h02, 8'hFF, 8'hD9};
    do_reset(1'b1);
    foreach (b[i]) s.push_back({1'b1, b[i]});
    model_run(s);
    send_stream(s, 0);
    idle(6, 0);
    checks++; if (got_w.size() != exp_w.size()) begin
      errors++; $display("FAIL basic_count got %0d want %0d", got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL basic_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    w = (got_w.size() > 1) ? got_w[1] : 'x;
    checks++; if (w !== {1'b1, 4'b1100, 32'hFFD9_0000}) begin
      errors++; $display("FAIL basic_eoi_word got %h want %h", w, {1'b1, 4'b1100, 32'hFFD9_0000});
    end
    checks++; if (got_len.size() != 1 || got_len[0] != 6) begin
      errors++; $display("FAIL basic_len got n=%0d v=%0d want 6", got_len.size(), got_len.size() ? got_len[0] : -1);
    end
    checks++; if (len_cyc.size() != 1 || len_cyc[0] != byte_cyc[6] + 2) begin
      errors++; $display("FAIL basic_len_time got %0d want %0d", len_cyc.size() ? len_cyc[0] : -1, byte_cyc[6] + 2);
    end
  endtask

  task automatic test_long_frame();
    logic [8:0] s[$];
    logic [36:0] w;
    do_reset(1'b1);
    s.push_back({1'b1, 8'hFF});
    s.push_back({1'b1, 8'hD8});
    for (int i = 0; i < 61; i++) s.push_back({1'b1, 8'($urandom_range(0, 254))});
    s.push_back({1'b1, 8'hFF});
    s.push_back({1'b1, 8'hD9});
    model_run(s);
    send_stream(s, 0);
    idle(8, 0);
    checks++; if (got_w.size() != 17) begin
      errors++; $display("FAIL long_count got %0d want 17", got_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL long_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    w = (got_w.size() > 16) ? got_w[16] : 'x;
    checks++; if (w[36:32] !== 5'b11000) begin
      errors++; $display("FAIL long_last_keep got %b want 11000", w[36:32]);
    end
    checks++; if (got_cyc.size() == 0 || got_cyc[0] != byte_cyc[3] + 2) begin
      errors++; $display("FAIL long_first_valid got %0d want %0d", got_cyc.size() ? got_cyc[0] : -1, byte_cyc[3] + 2);
    end
    checks++; if (got_len.size() != 1 || got_len[0] != 65) begin
      errors++; $display("FAIL long_len got %0d want 65", got_len.size() ? got_len[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] s[$];
    bit held_ok, seen;
    held_ok = 1;
    seen = 0;
    do_reset(1'b0);
    s.push_back({1'b1, 8'hFF});
    s.push_back({1'b1, 8'hD8});
    for (int i = 2; i < 40; i++) s.push_back({1'b1, 8'($urandom_range(0, 254))});
    model_run(s);
    for (int i = 0; i < 40; i++) begin
      JFIF_data = s[i][7:0];
      fifo_wr_req = 1'b1;
      @(posedge sys_clk);
      #1;
      if (m_valid) seen = 1;
      if (m_valid && m_data !== exp_w[0][31:0]) held_ok = 0;
      if (i == 14) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_full_low got %b want 0", fifo_full); end
      end
      if (i == 21) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full_high got %b want 1", fifo_full); end
      end
      if (i == 35) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_early got %b want 0", overflow); end
      end
      if (i == 37) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_set got %b want 1", overflow); end
      end
    end
    fifo_wr_req = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      if (m_valid && m_data !== exp_w[0][31:0]) held_ok = 0;
    end
    checks++; if (!(seen && held_ok)) begin
      errors++; $display("FAIL bp_hold got data %h valid %b want %h held", m_data, m_valid, exp_w[0][31:0]);
    end
    clear_obs();
    m_ready = 1'b1;
    repeat (8) begin
      @(posedge sys_clk);
      #1;
    end
    checks++; if (got_w.size() != 8) begin
      errors++; $display("FAIL bp_drain_count got %0d want 8", got_w.size());
    end
    checks++; if (m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain_empty got %b want 0", m_valid);
    end
    checks++; if (got_cyc.size() != 8 || got_cyc[7] - got_cyc[0] != 7) begin
      errors++; $display("FAIL bp_drain_rate got span %0d want 7", got_cyc.size() == 8 ? got_cyc[7] - got_cyc[0] : -1);
    end
    for (int i = 0; i < 8 && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    logic [8:0] s[$];
    logic [36:0] w;
    b = '{8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD9, 8'hFF, 8'hD8, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hD9};
    do_reset(1'b1);
    foreach (b[i]) s.push_back({1'b1, b[i]});
    model_run(s);
    send_stream(s, 0);
    idle(6, 0);
    checks++; if (got_len.size() != 2 || got_len[0] != 5 || got_len[1] != 7) begin
      errors++; $display("FAIL b2b_lens got n=%0d first=%0d want 5,7", got_len.size(), got_len.size() ? got_len[0] : -1);
    end
    w = (got_w.size() > 2) ? got_w[2] : 'x;
    checks++; if (w !== {1'b0, 4'b1111, 32'hFFD8_BBCC}) begin
      errors++; $display("FAIL b2b_second_first got %h want %h", w, {1'b0, 4'b1111, 32'hFFD8_BBCC});
    end
    checks++; if (got_w.size() != exp_w.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [8:0] s[$];
    do_reset(1'b0);
    s.push_back({1'b1, 8'hFF});
    s.push_back({1'b1, 8'hD8});
    for (int i = 0; i < 20; i++) s.push_back({1'b1, 8'($urandom_range(0, 254))});
    send_stream(s, 0);
    idle(3, 0);
    checks++; if (fifo_full !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL mid_prefill got full=%b valid=%b want 1,1", fifo_full, m_valid);
    end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++; if (m_valid !== 1'b0 || fifo_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset got valid=%b full=%b want 0,0", m_valid, fifo_full);
    end
    sys_rst = 1'b0;
    clear_obs();
    m_ready = 1'b1;
    b = '{8'h01, 8'h02, 8'hD9, 8'hFF, 8'hD9, 8'h03, 8'hFF, 8'hD8, 8'h11, 8'h22, 8'hFF, 8'hD9};
    s.delete();
    foreach (b[i]) s.push_back({1'b1, b[i]});
    model_run(s);
    send_stream(s, 0);
    idle(6, 0);
    checks++; if (got_w.size() != exp_w.size()) begin
      errors++; $display("FAIL mid_count got %0d want %0d", got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL mid_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    checks++; if (got_len.size() != 1 || got_len[0] != 6) begin
      errors++; $display("FAIL mid_len got %0d want 6", got_len.size() ? got_len[0] : -1);
    end
  endtask

  task automatic test_random_ready();
    logic [7:0] b[$];
    logic [8:0] s[$];
    do_reset(1'b1);
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) b.push_back(8'($urandom_range(0, 254)));
      b.push_back(8'hFF);
      b.push_back(8'hD8);
      repeat ($urandom_range(1, 24)) b.push_back(8'($urandom_range(0, 255)));
      b.push_back(8'hFF);
      b.push_back(8'hD9);
    end
    foreach (b[i]) begin
      if ($urandom_range(0, 3) == 0) s.push_back({1'b0, 8'h00});
      s.push_back({1'b1, b[i]});
    end
    model_run(s);
    send_stream(s, 1);
    idle(80, 1);
    checks++; if (got_w.size() != exp_w.size()) begin
      errors++; $display("FAIL rnd_count got %0d want %0d", got_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin
        errors++; $display("FAIL rnd_word%0d got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    checks++; if (got_len.size() != exp_len.size()) begin
      errors++; $display("FAIL rnd_len_count got %0d want %0d", got_len.size(), exp_len.size());
    end
    for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) begin
      checks++; if (got_len[i] != exp_len[i]) begin
        errors++; $display("FAIL rnd_len%0d got %0d want %0d", i, got_len[i], exp_len[i]);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_ovf got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
